// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window datapath.
package conv_pkg;

   localparam int KSIZE  = 3;
   localparam int NUM_CH = 2;

   typedef logic [15:0]      fp16_t;
   typedef fp16_t [8:0]      win9_t;

endpackage

// File: rtl/conv_line_buf.sv
// Per-channel storage: two IMG_W-deep row buffers feeding a 3x3 shift window.
module conv_line_buf
   import conv_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int DATA_W = 16,
   parameter int COL_W  = $clog2(IMG_W)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   we,
   input  logic [COL_W-1:0]                       col,
   input  logic [DATA_W-1:0]                      pix,
   output logic [KSIZE*KSIZE-1:0][DATA_W-1:0]     win
);

   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] top, mid;

   assign top = lb1[col];
   assign mid = lb0[col];

   // Row storage carries no reset; stale columns are never part of an emitted window.
   always_ff @(posedge clk) begin
      if (we) begin
         lb1[col] <= lb0[col];
         lb0[col] <= pix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win <= '0;
      end else if (we) begin
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE-1; c++)
               win[r*KSIZE+c] <= win[r*KSIZE+c+1];
         win[KSIZE-1]       <= top;
         win[2*KSIZE-1]     <= mid;
         win[KSIZE*KSIZE-1] <= pix;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order two-channel pixel stream to 3x3 sliding windows with a single output slot.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   input  logic                                pix_valid,
   output logic                                pix_ready,
   input  logic [DATA_W-1:0]                   pix_ch1,
   input  logic [DATA_W-1:0]                   pix_ch2,
   output logic                                win_valid,
   input  logic                                win_ready,
   output logic [KSIZE*KSIZE-1:0][DATA_W-1:0]  win_ch1,
   output logic [KSIZE*KSIZE-1:0][DATA_W-1:0]  win_ch2,
   output logic                                win_last
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W-1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H-1);
   localparam logic [COL_W-1:0] COL_MIN = COL_W'(KSIZE-1);
   localparam logic [ROW_W-1:0] ROW_MIN = ROW_W'(KSIZE-1);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic acc, emit, col_last, row_last;

   logic [NUM_CH-1:0][DATA_W-1:0]                   pix;
   logic [NUM_CH-1:0][KSIZE*KSIZE-1:0][DATA_W-1:0]  win;

   // Slot drains and refills in the same cycle, so streaming runs without bubbles.
   assign pix_ready = !clear & (!win_valid | win_ready);
   assign acc       = pix_valid & pix_ready;
   assign col_last  = (col == COL_MAX);
   assign row_last  = (row == ROW_MAX);
   assign emit      = acc & (row >= ROW_MIN) & (col >= COL_MIN);

   assign pix = {pix_ch2, pix_ch1};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      conv_line_buf #(
         .IMG_W  (IMG_W),
         .DATA_W (DATA_W),
         .COL_W  (COL_W)
      ) u_lb (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (acc),
         .col   (col),
         .pix   (pix[g]),
         .win   (win[g])
      );
   end

   // Window regs only move on accept, and accept while full implies the slot drained.
   assign win_ch1 = win[0];
   assign win_ch2 = win[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else if (clear) begin
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         if (acc) begin
            col <= col_last ? '0 : col + COL_W'(1);
            if (col_last)
               row <= row_last ? '0 : row + ROW_W'(1);
         end
         if (emit) begin
            win_valid <= 1'b1;
            win_last  <= row_last & col_last;
         end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and seeded-random checks of conv_window_gen on a 4x4 frame.
module tb_conv_window_gen;
   import conv_pkg::*;

   localparam int W = 4;
   localparam int H = 4;

   logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0;
   logic pix_valid = 1'b0, win_ready = 1'b0;
   logic pix_ready, win_valid, win_last;
   logic [15:0] pix_ch1 = '0, pix_ch2 = '0;
   win9_t win_ch1, win_ch2;

   int checks = 0, failures = 0, cyc = 0, acc10 = -1;
   win9_t cap1[$], cap2[$];
   logic  capl[$];
   int    capc[$];
   int    newest[4] = '{10, 11, 14, 15};

   always #5 clk = ~clk;

   conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_ch1(pix_ch1), .pix_ch2(pix_ch2),
      .win_valid(win_valid), .win_ready(win_ready),
      .win_ch1(win_ch1), .win_ch2(win_ch2), .win_last(win_last)
   );

   // Pixel k of a run carries ch1 = k%16 and ch2 = 0x100+k; n is the newest pixel's in-frame index.
   function automatic win9_t exp_w(input int f, input int n, input bit ch2);
      win9_t w;
      int v;
      for (int i = 0; i < 9; i++) begin
         v = n - 10 + (i / 3) * 4 + (i % 3);
         w[i] = ch2 ? 16'(256 + 16 * f + v) : 16'(v);
      end
      return w;
   endfunction

   task automatic run_pixels(input int start, input int count, input logic wr);
      int k = start, sent = 0, tail = 0, guard = 0;
      cap1.delete(); cap2.delete(); capl.delete(); capc.delete();
      acc10 = -1;
      while ((sent < count || tail < 3) && guard < 400) begin
         @(negedge clk);
         cyc++; guard++;
         win_ready = wr;
         if (win_valid && win_ready) begin
            cap1.push_back(win_ch1); cap2.push_back(win_ch2);
            capl.push_back(win_last); capc.push_back(cyc);
         end
         if (sent < count) begin
            pix_valid = 1'b1; pix_ch1 = 16'(k % 16); pix_ch2 = 16'(256 + k);
         end else begin
            pix_valid = 1'b0; tail++;
         end
         #1;
         if (pix_valid && pix_ready) begin
            if (k % 16 == 10 && acc10 < 0) acc10 = cyc;
            k++; sent++;
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1; pix_valid = 1'b0;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; #1 rst_n = 1'b0; #2;
      checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
      checks++; if (win_last !== 1'b0) begin failures++; $display("FAIL reset_win_last got=%b exp=0", win_last); end
      checks++; if (win_ch1 !== '0) begin failures++; $display("FAIL reset_win_ch1 got=%h exp=0", win_ch1); end
      checks++; if (win_ch2 !== '0) begin failures++; $display("FAIL reset_win_ch2 got=%h exp=0", win_ch2); end
      checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_streaming();
      win9_t first;
      first = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
      run_pixels(0, 16, 1'b1);
      checks++; if (cap1.size() !== 4) begin failures++; $display("FAIL stream_count got=%0d exp=4", cap1.size()); end
      if (cap1.size() > 0) begin
         checks++; if (cap1[0] !== first) begin failures++; $display("FAIL stream_first got=%h exp=%h", cap1[0], first); end
         checks++; if (capc[0] !== acc10 + 1) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", capc[0], acc10 + 1); end
      end
      for (int j = 0; j < cap1.size() && j < 4; j++) begin
         checks++; if (cap1[j] !== exp_w(0, newest[j], 0)) begin failures++; $display("FAIL stream_ch1[%0d] got=%h exp=%h", j, cap1[j], exp_w(0, newest[j], 0)); end
         checks++; if (cap2[j] !== exp_w(0, newest[j], 1)) begin failures++; $display("FAIL stream_ch2[%0d] got=%h exp=%h", j, cap2[j], exp_w(0, newest[j], 1)); end
         checks++; if (capl[j] !== (j == 3)) begin failures++; $display("FAIL stream_last[%0d] got=%b exp=%b", j, capl[j], j == 3); end
      end
      checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", win_valid); end
   endtask

   task automatic test_backpressure();
      int k = 0, guard = 0;
      do_clear();
      win_ready = 1'b1;
      while (guard < 50) begin
         @(negedge clk);
         guard++;
         if (win_valid) break;
         pix_valid = 1'b1; pix_ch1 = 16'(k % 16); pix_ch2 = 16'(256 + k);
         #1;
         if (pix_valid && pix_ready) k++;
      end
      checks++; if (k !== 11 || win_valid !== 1'b1) begin failures++; $display("FAIL bp_first got=%0d/%b exp=11/1", k, win_valid); end
      win_ready = 1'b0; pix_ch1 = 16'(k % 16); pix_ch2 = 16'(256 + k);
      #1;
      checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL bp_ready0 got=%b exp=0", pix_ready); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", c, win_valid); end
         checks++; if (win_ch1 !== exp_w(0, 10, 0) || win_ch2 !== exp_w(0, 10, 1)) begin failures++; $display("FAIL bp_hold_data[%0d] got=%h exp=%h", c, win_ch1, exp_w(0, 10, 0)); end
         checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0", c, pix_ready); end
      end
      run_pixels(k, 16 - k, 1'b1);
      checks++; if (cap1.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", cap1.size()); end
      for (int j = 0; j < cap1.size() && j < 4; j++) begin
         checks++; if (cap1[j] !== exp_w(0, newest[j], 0) || cap2[j] !== exp_w(0, newest[j], 1)) begin failures++; $display("FAIL bp_win[%0d] got=%h exp=%h", j, cap1[j], exp_w(0, newest[j], 0)); end
      end
   endtask

   task automatic test_back_to_back();
      do_clear();
      run_pixels(0, 32, 1'b1);
      checks++; if (cap1.size() !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", cap1.size()); end
      for (int j = 0; j < cap1.size() && j < 8; j++) begin
         checks++; if (cap1[j] !== exp_w(j / 4, newest[j % 4], 0)) begin failures++; $display("FAIL b2b_ch1[%0d] got=%h exp=%h", j, cap1[j], exp_w(j / 4, newest[j % 4], 0)); end
         checks++; if (cap2[j] !== exp_w(j / 4, newest[j % 4], 1)) begin failures++; $display("FAIL b2b_ch2[%0d] got=%h exp=%h", j, cap2[j], exp_w(j / 4, newest[j % 4], 1)); end
         checks++; if (capl[j] !== (j % 4 == 3)) begin failures++; $display("FAIL b2b_last[%0d] got=%b exp=%b", j, capl[j], j % 4 == 3); end
      end
   endtask

   task automatic test_clear();
      do_clear();
      run_pixels(0, 10, 1'b1);
      checks++; if (cap1.size() !== 0) begin failures++; $display("FAIL clr_early got=%0d exp=0", cap1.size()); end
      @(negedge clk);
      clear = 1'b1; pix_valid = 1'b1; pix_ch1 = 16'd10; pix_ch2 = 16'h10a;
      #1;
      checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%b exp=0", pix_ready); end
      @(negedge clk);
      clear = 1'b0; pix_valid = 1'b0;
      run_pixels(0, 11, 1'b0);
      checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL clr_pending got=%b exp=1", win_valid); end
      @(negedge clk);
      clear = 1'b1; pix_valid = 1'b1;
      #1;
      checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL clr_ready2 got=%b exp=0", pix_ready); end
      @(negedge clk);
      clear = 1'b0; pix_valid = 1'b0;
      checks++; if (win_valid !== 1'b0 || win_last !== 1'b0) begin failures++; $display("FAIL clr_drop got=%b/%b exp=0/0", win_valid, win_last); end
      run_pixels(0, 16, 1'b1);
      checks++; if (cap1.size() !== 4) begin failures++; $display("FAIL clr_count got=%0d exp=4", cap1.size()); end
      for (int j = 0; j < cap1.size() && j < 4; j++) begin
         checks++; if (cap1[j] !== exp_w(0, newest[j], 0) || cap2[j] !== exp_w(0, newest[j], 1) || capl[j] !== (j == 3)) begin failures++; $display("FAIL clr_win[%0d] got=%h exp=%h", j, cap1[j], exp_w(0, newest[j], 0)); end
      end
   endtask

   task automatic test_reset_midframe();
      do_clear();
      run_pixels(0, 11, 1'b0);
      checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre got=%b exp=1", win_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (win_valid !== 1'b0 || win_last !== 1'b0) begin failures++; $display("FAIL mrst_flags got=%b/%b exp=0/0", win_valid, win_last); end
      checks++; if (win_ch1 !== '0 || win_ch2 !== '0) begin failures++; $display("FAIL mrst_data got=%h exp=0", win_ch1); end
      @(negedge clk);
      rst_n = 1'b1;
      run_pixels(0, 16, 1'b1);
      checks++; if (cap1.size() !== 4) begin failures++; $display("FAIL mrst_count got=%0d exp=4", cap1.size()); end
      for (int j = 0; j < cap1.size() && j < 4; j++) begin
         checks++; if (cap1[j] !== exp_w(0, newest[j], 0) || cap2[j] !== exp_w(0, newest[j], 1) || capl[j] !== (j == 3)) begin failures++; $display("FAIL mrst_win[%0d] got=%h exp=%h", j, cap1[j], exp_w(0, newest[j], 0)); end
      end
   endtask

   task automatic test_random();
      win9_t q1[$], q2[$], h1, h2, e1, e2;
      logic  ql[$], hl, el, hold;
      int k = 0, taken = 0, guard = 0, n;
      hold = 1'b0; h1 = '0; h2 = '0; hl = 1'b0;
      void'($urandom(32'd2024));
      do_clear();
      while ((k < 16000 || q1.size() != 0 || win_valid) && guard < 80000) begin
         @(negedge clk);
         guard++;
         if (hold) begin
            checks++;
            if (win_valid !== 1'b1 || win_ch1 !== h1 || win_ch2 !== h2 || win_last !== hl) begin
               failures++;
               if (failures < 20) $display("FAIL rand_hold got=%h exp=%h", win_ch1, h1);
            end
         end
         win_ready = ($urandom_range(3) != 0);
         pix_valid = (k < 16000) && ($urandom_range(3) != 0);
         pix_ch1 = 16'(k % 16); pix_ch2 = 16'(256 + k);
         #1;
         if (win_valid && !win_ready) begin
            checks++;
            if (pix_ready !== 1'b0) begin failures++; if (failures < 20) $display("FAIL rand_stall_ready got=%b exp=0", pix_ready); end
         end
         if (win_valid && win_ready) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               if (failures < 20) $display("FAIL rand_extra got=%h exp=none", win_ch1);
            end else begin
               e1 = q1.pop_front(); e2 = q2.pop_front(); el = ql.pop_front();
               if (win_ch1 !== e1 || win_ch2 !== e2 || win_last !== el) begin
                  failures++;
                  if (failures < 20) $display("FAIL rand_win[%0d] got=%h/%b exp=%h/%b", taken, win_ch2, win_last, e2, el);
               end
            end
            taken++;
         end
         hold = win_valid && !win_ready;
         h1 = win_ch1; h2 = win_ch2; hl = win_last;
         if (pix_valid && pix_ready) begin
            n = k % 16;
            if (n == 10 || n == 11 || n == 14 || n == 15) begin
               q1.push_back(exp_w(k / 16, n, 0));
               q2.push_back(exp_w(k / 16, n, 1));
               ql.push_back(n == 15);
            end
            k++;
         end
      end
      pix_valid = 1'b0; win_ready = 1'b0;
      checks++; if (k !== 16000) begin failures++; $display("FAIL rand_pixels got=%0d exp=16000", k); end
      checks++; if (taken !== 4000) begin failures++; $display("FAIL rand_windows got=%0d exp=4000", taken); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
